// File: rtl/imem_loadable.sv
// Loadable instruction store: sequential loader port fills the array,
// then a registered valid/ready fetch port serves the pipeline.
module imem_loadable #(
    parameter int N      = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_valid,
    input  logic [N-1:0]      ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              reload,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_oob,
    input  logic              rsp_ready,
    output logic [ADDR_W:0]   prog_len
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic              reload_pend;
    logic [N-1:0]      mem [DEPTH];

    logic ld_fire;
    logic ld_end;
    logic accept;
    logic rsp_free;
    logic drain;
    logic oob;

    assign rsp_free = !rsp_valid || rsp_ready;
    assign ld_fire  = ld_valid && ld_ready;
    assign ld_end   = ld_fire &&
                      (ld_last || wr_ptr == ADDR_W'(DEPTH - 1));
    assign accept   = req_valid && req_ready;
    assign oob      = {1'b0, req_addr} >= prog_len;
    // Leave RUN only once the in-flight response is gone or retiring.
    assign drain    = (state == RUN) && reload_pend && rsp_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: if (ld_end) state_nx = RUN;
            RUN:  if (drain)  state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        ld_ready  = (state == LOAD);
        req_ready = (state == RUN) && !reload_pend && rsp_free;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            prog_len    <= '0;
            reload_pend <= 1'b0;
            ld_done     <= 1'b0;
        end else begin
            ld_done <= ld_end;
            if (drain) begin
                wr_ptr      <= '0;
                prog_len    <= '0;
                reload_pend <= 1'b0;
            end else begin
                if (ld_fire) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    prog_len <= {1'b0, wr_ptr} + 1'b1;
                end
                if (state == RUN && reload) begin
                    reload_pend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_oob   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_oob   <= oob;
            rsp_data  <= oob ? '0 : mem[req_addr];
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: load, fetch, backpressure,
// full-depth load, reload under stall and asynchronous reset.
module tb_imem_loadable;

    localparam int N      = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ld_valid;
    logic [N-1:0]      ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              reload;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [N-1:0]      rsp_data;
    logic              rsp_oob;
    logic              rsp_ready;
    logic [ADDR_W:0]   prog_len;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    imem_loadable #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .reload    (reload),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_oob   (rsp_oob),
        .rsp_ready (rsp_ready),
        .prog_len  (prog_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        reload    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;

        // reset state
        #12;
        chk("rst_prog_len", 64'(prog_len), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_ld_done", 64'(ld_done), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        tick();

        // load 47 words
        for (int i = 0; i < 47; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA000_0000 + 32'(i);
            ld_last  = (i == 46);
            tick();
            if (ld_done) pulses++;
        end
        chk("load47_prog_len", 64'(prog_len), 64'd47);
        chk("load47_ld_ready", 64'(ld_ready), 64'd0);
        chk("load47_req_ready", 64'(req_ready), 64'd1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        if (ld_done) pulses++;
        chk("load47_done_pulses", 64'(pulses), 64'd1);

        // back-to-back fetch 0..49
        rsp_ready = 1'b1;
        for (int a = 0; a < 50; a++) begin
            req_valid = 1'b1;
            req_addr  = ADDR_W'(a);
            #0;
            if (a == 0) chk("fetch_req_ready", 64'(req_ready), 64'd1);
            tick();
            chk("fetch_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("fetch_rsp_data", 64'(rsp_data),
                (a < 47) ? 64'(32'hA000_0000 + 32'(a)) : 64'd0);
            chk("fetch_rsp_oob", 64'(rsp_oob), (a < 47) ? 64'd0 : 64'd1);
        end
        req_valid = 1'b0;
        tick();
        chk("retire_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("retire_hold_oob", 64'(rsp_oob), 64'd1);

        // backpressure on addr 5
        req_valid = 1'b1;
        req_addr  = 6'd5;
        rsp_ready = 1'b0;
        tick();
        req_addr = 6'd6;
        for (int c = 0; c < 3; c++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data", 64'(rsp_data), 64'hA000_0005);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("bp_next_valid", 64'(rsp_valid), 64'd1);
        chk("bp_next_data", 64'(rsp_data), 64'hA000_0006);
        tick();
        chk("bp_single_rsp", 64'(rsp_valid), 64'd0);

        // reload, then fill every location without ld_last
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_req_ready", 64'(req_ready), 64'd0);
        tick();
        chk("reload_ld_ready", 64'(ld_ready), 64'd1);
        chk("reload_prog_len", 64'(prog_len), 64'd0);
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hB000_0000 + 32'(i);
            ld_last  = 1'b0;
            tick();
            if (i == 62) chk("full_ld_ready_mid", 64'(ld_ready), 64'd1);
        end
        chk("full_ld_done", 64'(ld_done), 64'd1);
        chk("full_prog_len", 64'(prog_len), 64'd64);
        chk("full_ld_ready", 64'(ld_ready), 64'd0);
        ld_data = 32'hFFFF_FFFF;
        tick();
        ld_valid = 1'b0;
        chk("extra_ld_ready", 64'(ld_ready), 64'd0);
        chk("extra_prog_len", 64'(prog_len), 64'd64);
        chk("extra_ld_done", 64'(ld_done), 64'd0);
        req_valid = 1'b1;
        req_addr  = 6'd63;
        tick();
        chk("full_fetch63_data", 64'(rsp_data), 64'hB000_003F);
        chk("full_fetch63_oob", 64'(rsp_oob), 64'd0);
        req_addr = 6'd0;
        tick();
        chk("full_fetch0_data", 64'(rsp_data), 64'hB000_0000);
        req_valid = 1'b0;
        tick();

        // reload while addr 2 is stalled
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 6'd2;
        tick();
        req_valid = 1'b0;
        chk("stall_rsp_data", 64'(rsp_data), 64'hB000_0002);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        tick();
        chk("stall_still_run", 64'(ld_ready), 64'd0);
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("stall_prog_len", 64'(prog_len), 64'd64);
        rsp_ready = 1'b1;
        tick();
        chk("stall_load_ready", 64'(ld_ready), 64'd1);
        chk("stall_load_len", 64'(prog_len), 64'd0);
        chk("stall_rsp_gone", 64'(rsp_valid), 64'd0);
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("one_prog_len", 64'(prog_len), 64'd1);
        req_valid = 1'b1;
        req_addr  = 6'd0;
        tick();
        chk("one_fetch0_data", 64'(rsp_data), 64'hDEAD_BEEF);
        chk("one_fetch0_oob", 64'(rsp_oob), 64'd0);
        req_addr = 6'd1;
        tick();
        req_valid = 1'b0;
        chk("one_fetch1_data", 64'(rsp_data), 64'd0);
        chk("one_fetch1_oob", 64'(rsp_oob), 64'd1);

        // async reset after 10 loader writes
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hC000_0000 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        chk("pre_arst_prog_len", 64'(prog_len), 64'd10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_prog_len", 64'(prog_len), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_ld_ready", 64'(ld_ready), 64'd1);
        #2;
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hD000_0000 + 32'(i);
            ld_last  = (i == 2);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("after_arst_prog_len", 64'(prog_len), 64'd3);
        chk("after_arst_ld_done", 64'(ld_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor of the fixed single-cycle instruction memory: word-addressed instruction store, written at run time through a sequential loader port, read through a registered valid/ready fetch port.
- Sits between the program loader (testbench or boot logic) and the fetch stage of the pipelined processor.
- Reads beyond the loaded program length return zero and are flagged.

Parameters:
- N, 32, instruction word width in bits.
- DEPTH, 64, number of words; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), word-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader word present.
- ld_data  in  N  loader instruction word.
- ld_last  in  1  qualifies ld_valid; marks the final word of the program.
- ld_ready  out  1  store accepts a loader word.
- ld_done  out  1  one-cycle pulse when loading completes.
- reload  in  1  request to discard the program and re-enter loading.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_W  word address of the fetch.
- req_ready  out  1  fetch request accepted this cycle.
- rsp_valid  out  1  fetch response present.
- rsp_data  out  N  fetched word.
- rsp_oob  out  1  response address was >= prog_len.
- rsp_ready  in  1  consumer takes the response.
- prog_len  out  ADDR_W+1  number of words loaded.

Behaviour:
- States: LOAD and RUN.
- Reset (async, immediate) sets: state=LOAD, wr_ptr=0, prog_len=0, rsp_valid=0, rsp_data=0, rsp_oob=0, ld_done=0, reload_pend=0. Memory array is not cleared; its contents are don't-care.
- ld_ready = (state==LOAD). With reset_n released, it is 1.
- req_ready = (state==RUN) && !reload_pend && (!rsp_valid || rsp_ready).
- LOAD state:
  - On each ld_valid && ld_ready: mem[wr_ptr] <= ld_data; wr_ptr++; prog_len <= wr_ptr+1.
  - If that write has ld_last=1, or wr_ptr==DEPTH-1: next state RUN, ld_done=1 for the following cycle only.
  - ld_valid is ignored in RUN.
  - req_valid is ignored in LOAD; no response is generated.
- RUN state, fetch path:
  - Accept = req_valid && req_ready.
  - On accept, at the next edge: rsp_valid=1; rsp_oob=(req_addr >= prog_len); rsp_data = rsp_oob ? 0 : mem[req_addr].
  - Latency is exactly 1 cycle, with one response in flight at most.
  - Back-to-back accepts give one response per cycle while rsp_ready=1.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data and rsp_oob are held stable and req_ready=0.
- Response retirement: if rsp_valid && rsp_ready with no new accept, rsp_valid=0 at the next edge. rsp_data and rsp_oob keep their last values.
- Simultaneous retire and accept: the response is replaced by the new one, with no bubble.
- Reload:
  - reload=1 in RUN sets reload_pend; req_ready drops immediately.
  - Once rsp_valid=0, or at the edge where the pending response is taken: state=LOAD, wr_ptr=0, prog_len=0, reload_pend=0.
  - reload in LOAD has no effect.
- Boundaries:
  - prog_len==DEPTH: no address is out of range.
  - prog_len==0 is reachable only during LOAD.
  - A write to the last location auto-terminates loading even with ld_last=0.
  - Reset mid-load or mid-fetch discards all progress; no partial response is emitted.

Test Plan:
- Reset, then load 47 words 32'hA000_0000+i, ld_last on i=46 -> ld_done pulses once; prog_len=47; ld_ready=0; req_ready=1.
- Fetch addr 0..49 back-to-back, rsp_ready=1 -> responses on consecutive cycles starting 1 cycle after the first accept:
  - addr 0..46 give A000_0000+addr with rsp_oob=0;
  - addr 47..49 give 0000_0000 with rsp_oob=1.
- Accept addr 5, then hold rsp_ready=0 for 3 cycles -> rsp_data=A000_0005 stable, req_ready=0 throughout; after release, exactly one response, next request accepted in the same cycle.
- Load 64 words with ld_last=0 -> RUN after the 64th write, prog_len=64; a 65th ld_valid is not accepted; fetch addr 63 returns the 64th word with rsp_oob=0.
- reload asserted while a response for addr 2 is stalled:
  - state stays RUN until rsp_ready=1, then LOAD, prog_len=0;
  - load 1 word 32'hDEAD_BEEF with ld_last -> fetch 0 returns DEAD_BEEF; fetch 1 returns 0 with rsp_oob=1.
- Assert reset_n=0 asynchronously after 10 loader writes -> prog_len=0, rsp_valid=0, ld_ready=1 without waiting for a clock edge; reload 3 words -> prog_len=3.
